// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared instruction-cache geometry and frame/address types.
package cpu_types_pkg;
    localparam int ITAG_W  = 26;
    localparam int IIDX_W  = 4;
    localparam int IFRAMES = 16;
    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;
    typedef struct packed {
        logic              valid;
        logic [ITAG_W-1:0] tag;
        logic [31:0]       data;
    } icache_frame_t;
endpackage

// File: rtl/icache.sv
// icache: direct-mapped 16-word instruction cache with a two-state miss FSM.
// Define ICACHE_STATS_EN to add the hitcnt/misscnt event counters.
module icache
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic [31:0] imemload,
    output logic        ihit,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic [31:0] iload,
    input  logic        iwait
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hitcnt,
    output logic [31:0] misscnt
`endif
);
    typedef enum logic {IDLE, FILL} state_t;

    state_t        r_state;
    icachef_t      r_miss;
    icache_frame_t r_frames [IFRAMES];
    icachef_t      w_addr;
    icache_frame_t w_frame;
    logic          w_hit;
    logic          w_fill;
    logic          w_unused_bytoff;

    assign w_addr          = icachef_t'(imemaddr);
    assign w_frame         = r_frames[w_addr.idx];
    assign w_unused_bytoff = ^w_addr.bytoff;
    // Outputs are held quiet while reset is asserted, whatever the arrays hold.
    assign w_hit    = !RST && r_state == IDLE && imemREN && w_frame.valid && w_frame.tag == w_addr.tag;
    assign w_fill   = !RST && r_state == FILL;
    assign ihit     = w_hit;
    assign imemload = w_hit ? w_frame.data : '0;
    assign iREN     = w_fill;
    assign iaddr    = w_fill ? r_miss : '0;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_miss  <= '0;
            for (int i = 0; i < IFRAMES; i++)
                r_frames[i].valid <= 1'b0;
        end else if (r_state == FILL) begin
            if (!iwait) begin
                r_frames[r_miss.idx] <= '{valid: 1'b1, tag: r_miss.tag, data: iload};
                r_state              <= IDLE;
            end
        end else if (imemREN && !w_hit) begin
            r_miss  <= w_addr;
            r_state <= FILL;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hitcnt;
    logic [31:0] r_misscnt;

    assign hitcnt  = r_hitcnt;
    assign misscnt = r_misscnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hitcnt  <= '0;
            r_misscnt <= '0;
        end else begin
            if (w_hit)
                r_hitcnt <= r_hitcnt + 32'd1;
            if (r_state == IDLE && imemREN && !w_hit)
                r_misscnt <= r_misscnt + 32'd1;
        end
    end
`endif
endmodule
